adder_response_checker: RTL and testbench

Synthesizable response checker for the ripple-carry adder. It receives each applied vector (a, b, carryin) together with the adder's response (sum, carryout) and compares the response against a golden a+b+carryin. It also confirms that vectors arrive in exhaustive ascending order {carryin,a,b} = 0 … 2^(2·WIDTH+1)−1, and it reports counts, the first failure, and a final pass/fail. It sits at the consuming end of the adder's exhaustive stimulus stream, on-chip or in a self-checking bench.

---
 rtl/adder_response_checker.sv | 108 ++++++++++
 tb/tb_adder_response_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_response_checker.sv
// Response checker for the ripple-carry adder: compares each applied vector's
// sum/carry-out against a golden a+b+carryin and confirms exhaustive ascending order.
module adder_response_checker #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 carryin,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 carryout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   vector_count,
    output logic [ERR_W-1:0]     error_count,
    output logic                 seq_error,
    output logic                 first_fail_valid,
    output logic [2*WIDTH:0]     first_fail_vec,
    output logic [WIDTH:0]       first_fail_got
);

    localparam int unsigned VW = 2 * WIDTH + 1;
    localparam int unsigned CW = 2 * WIDTH + 2;
    localparam int unsigned SW = WIDTH + 1;
    // Count value held just before the final vector of the sweep is accepted.
    localparam logic [CW-1:0] LAST_CNT = {1'b0, {VW{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic [VW-1:0]    vec;
    logic [SW-1:0]    exp_resp;
    logic [SW-1:0]    got_resp;
    logic             mismatch;
    logic             out_of_order;
    logic             last_vec;
    logic [ERR_W-1:0] err_next;
    logic             seq_next;

    // Golden model and per-vector check results.
    always_comb begin
        vec          = {carryin, a, b};
        exp_resp     = SW'(a) + SW'(b) + SW'(carryin);
        got_resp     = {carryout, sum};
        mismatch     = (got_resp != exp_resp);
        out_of_order = (vec != vector_count[VW-1:0]);
        last_vec     = (vector_count == LAST_CNT);
        err_next     = error_count;
        if (mismatch && (error_count != {ERR_W{1'b1}})) begin
            err_next = error_count + ERR_W'(1);
        end
        seq_next     = seq_error | out_of_order;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            vector_count     <= '0;
            error_count      <= '0;
            seq_error        <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_got   <= '0;
        end else if (start) begin
            // start wins over any vector presented in the same cycle
            state            <= RUN;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            vector_count     <= '0;
            error_count      <= '0;
            seq_error        <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_got   <= '0;
        end else if ((state == RUN) && in_valid) begin
            vector_count <= vector_count + CW'(1);
            error_count  <= err_next;
            seq_error    <= seq_next;
            if (mismatch && !first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_vec   <= vec;
                first_fail_got   <= got_resp;
            end
            // Termination is by count only, regardless of sequence errors.
            if (last_vec) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_next == '0) && !seq_next;
            end
        end
    end

endmodule

// File: tb/tb_adder_response_checker.sv
// Directed bench for adder_response_checker: full sweeps with good and faulty
// adders, sequence faults, in_valid gaps, mid-run reset and error saturation.
module tb_adder_response_checker;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned NVEC  = 512;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] a, b, sum;
    logic             carryin, carryout;
    int               mode;
    logic [WIDTH:0]   resp;

    logic             busy, done, pass, seq_error, first_fail_valid;
    logic [9:0]       vector_count;
    logic [15:0]      error_count;
    logic [8:0]       first_fail_vec;
    logic [4:0]       first_fail_got;

    logic             busy4, done4, pass4, seq_error4, first_fail_valid4;
    logic [9:0]       vector_count4;
    logic [3:0]       error_count4;
    logic [8:0]       first_fail_vec4;
    logic [4:0]       first_fail_got4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Stimulus-side adder: mode 0 correct, mode 1 sum[0] stuck-at-0.
    always_comb begin
        resp = {1'b0, a} + {1'b0, b} + {4'b0, carryin};
        if (mode == 1) resp[0] = 1'b0;
        {carryout, sum} = resp;
    end

    adder_response_checker #(.WIDTH(4), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .carryin(carryin), .sum(sum), .carryout(carryout),
        .busy(busy), .done(done), .pass(pass), .vector_count(vector_count),
        .error_count(error_count), .seq_error(seq_error),
        .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec),
        .first_fail_got(first_fail_got)
    );

    // Narrow-counter instance fed by an adder whose outputs are always 0.
    adder_response_checker #(.WIDTH(4), .ERR_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .carryin(carryin), .sum(4'h0), .carryout(1'b0),
        .busy(busy4), .done(done4), .pass(pass4), .vector_count(vector_count4),
        .error_count(error_count4), .seq_error(seq_error4),
        .first_fail_valid(first_fail_valid4), .first_fail_vec(first_fail_vec4),
        .first_fail_got(first_fail_got4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        {carryin, a, b} = 9'(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Ascending sweep; gap inserts an idle cycle with junk operands after each vector.
    task automatic sweep(input bit gap);
        for (int i = 0; i < NVEC; i++) begin
            send(i);
            if (i == NVEC - 2) check_eq("done_before_last", 32'(done), 32'd0);
            if (gap) begin
                {carryin, a, b} = 9'($urandom_range(0, 511));
                tick();
                if (i == 10) check_eq("gap_count", 32'(vector_count), 32'd11);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_pass"}, 32'(pass), 32'd0);
        check_eq({tag, "_vcnt"}, 32'(vector_count), 32'd0);
        check_eq({tag, "_ecnt"}, 32'(error_count), 32'd0);
        check_eq({tag, "_seq"}, 32'(seq_error), 32'd0);
        check_eq({tag, "_ffv"}, 32'(first_fail_valid), 32'd0);
        check_eq({tag, "_ffvec"}, 32'(first_fail_vec), 32'd0);
        check_eq({tag, "_ffgot"}, 32'(first_fail_got), 32'd0);
    endtask

    initial begin
        mode = 0; reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; carryin = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_idle_outputs("reset");

        // Good adder, back-to-back sweep.
        pulse_start();
        check_eq("t1_busy_after_start", 32'(busy), 32'd1);
        sweep(1'b0);
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd0);
        check_eq("t1_pass", 32'(pass), 32'd1);
        check_eq("t1_vcnt", 32'(vector_count), 32'd512);
        check_eq("t1_ecnt", 32'(error_count), 32'd0);
        check_eq("t1_seq", 32'(seq_error), 32'd0);
        check_eq("t1_ffv", 32'(first_fail_valid), 32'd0);
        check_eq("sat_ecnt", 32'(error_count4), 32'd15);
        check_eq("sat_ffvec", 32'(first_fail_vec4), 32'h001);
        check_eq("sat_ffgot", 32'(first_fail_got4), 32'h00);
        check_eq("sat_pass", 32'(pass4), 32'd0);
        check_eq("sat_done", 32'(done4), 32'd1);

        // Start from DONE clears results; then stuck-at sum[0] sweep.
        mode = 1;
        pulse_start();
        check_eq("restart_busy", 32'(busy4), 32'd1);
        check_eq("restart_done", 32'(done4), 32'd0);
        check_eq("restart_ecnt", 32'(error_count4), 32'd0);
        check_eq("restart_ffv", 32'(first_fail_valid4), 32'd0);
        check_eq("restart_vcnt", 32'(vector_count), 32'd0);
        sweep(1'b0);
        check_eq("t2_done", 32'(done), 32'd1);
        check_eq("t2_ecnt", 32'(error_count), 32'd256);
        check_eq("t2_ffv", 32'(first_fail_valid), 32'd1);
        check_eq("t2_ffvec", 32'(first_fail_vec), 32'h001);
        check_eq("t2_ffgot", 32'(first_fail_got), 32'h00);
        check_eq("t2_pass", 32'(pass), 32'd0);
        check_eq("t2_seq", 32'(seq_error), 32'd0);

        // Vector 4 duplicated, 5 skipped.
        mode = 0;
        pulse_start();
        for (int i = 0; i < NVEC; i++) begin
            send((i == 5) ? 4 : i);
            if (i == NVEC - 2) check_eq("t3_done_early", 32'(done), 32'd0);
        end
        check_eq("t3_done", 32'(done), 32'd1);
        check_eq("t3_seq", 32'(seq_error), 32'd1);
        check_eq("t3_ecnt", 32'(error_count), 32'd0);
        check_eq("t3_pass", 32'(pass), 32'd0);
        check_eq("t3_vcnt", 32'(vector_count), 32'd512);

        // in_valid toggling with junk between valid vectors.
        pulse_start();
        sweep(1'b1);
        check_eq("t4_done", 32'(done), 32'd1);
        check_eq("t4_vcnt", 32'(vector_count), 32'd512);
        check_eq("t4_pass", 32'(pass), 32'd1);
        check_eq("t4_seq", 32'(seq_error), 32'd0);

        // Start with a vector in the same cycle drops that vector.
        {carryin, a, b} = 9'd0;
        in_valid = 1'b1;
        pulse_start();
        in_valid = 1'b0;
        check_eq("start_prio_vcnt", 32'(vector_count), 32'd0);

        // Mid-run reset, then vectors without start are ignored.
        for (int i = 0; i < 100; i++) send(i);
        check_eq("t5_vcnt100", 32'(vector_count), 32'd100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("midreset");
        for (int i = 0; i < 10; i++) send(i);
        check_eq("t5_nostart_vcnt", 32'(vector_count), 32'd0);
        check_eq("t5_nostart_busy", 32'(busy), 32'd0);
        pulse_start();
        sweep(1'b0);
        check_eq("t5_done", 32'(done), 32'd1);
        check_eq("t5_pass", 32'(pass), 32'd1);
        check_eq("t5_vcnt", 32'(vector_count), 32'd512);

        // Vectors after DONE are ignored.
        send(0);
        check_eq("post_done_vcnt", 32'(vector_count), 32'd512);
        check_eq("post_done_hold", 32'(done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
